// File: rtl/axil_regbank_slave.sv
// -----------------------------------------------------------------------------
// axil_regbank_slave
//
// AXI4-Lite slave that exposes NUM_REGS 32-bit read/write control registers.
// The write and read channels are served by two independent FSMs. Byte strobes
// are honoured on writes. Accesses whose word index is NUM_REGS or above get a
// SLVERR response; such a read returns zero data.
//
// Ports
//   ACLK, ARESET        clock (rising edge), synchronous active-high reset
//   S_AXI_AW*           write address channel (AWPROT is ignored)
//   S_AXI_W*            write data channel with byte strobes
//   S_AXI_B*            write response channel (00 OKAY, 10 SLVERR)
//   S_AXI_AR*           read address channel (ARPROT is ignored)
//   S_AXI_R*            read data channel (00 OKAY, 10 SLVERR)
//   reg_out             all register contents, reg i at [32i+31:32i]
//   reg_wr_pulse        one-cycle pulse per register, one cycle after its write
// -----------------------------------------------------------------------------
module axil_regbank_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t r_wr_state, w_wr_state_next;
    rd_state_t r_rd_state, w_rd_state_next;

    logic [DW-1:0]       r_regs [NUM_REGS];
    logic                r_aw_held, r_w_held;
    logic [IDX_W-1:0]    r_aw_idx;
    logic [DW-1:0]       r_wdata;
    logic [SW-1:0]       r_wstrb;
    logic                r_bvalid, r_rvalid;
    logic [1:0]          r_bresp, r_rresp;
    logic [DW-1:0]       r_rdata;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
    logic [DW-1:0]       w_wr_data, w_rd_word;
    logic [SW-1:0]       w_wr_strb;
    logic                w_wr_in_range, w_rd_in_range;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic                w_unused;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write channel ----------------
    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;

    // Use the held copy if one exists, otherwise the beat handshaking this edge.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_held  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
    assign w_commit  = (r_wr_state == WR_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_in_range = (32'(w_wr_idx) < NUM_REGS);

    always_comb begin
        w_wr_state_next = r_wr_state;
        S_AXI_AWREADY   = 1'b0;
        S_AXI_WREADY    = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                S_AXI_AWREADY = ~r_aw_held;
                S_AXI_WREADY  = ~r_w_held;
                if (w_commit) w_wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                if (r_bvalid && S_AXI_BREADY) w_wr_state_next = WR_IDLE;
            end
            default: w_wr_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
        end else begin
            r_wr_state <= w_wr_state_next;
            r_wr_pulse <= w_wr_sel;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_in_range ? 2'b00 : 2'b10;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Per-register write select; no index matches when the access is out of range.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_wr_sel[gi]          = w_commit & (w_wr_idx == IDX_W'(gi));
            assign reg_out[32*gi +: 32]  = r_regs[gi];
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read channel ----------------
    assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_in_range = (32'(w_rd_idx) < NUM_REGS);

    // Read mux yields zero for indices with no register behind them.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == IDX_W'(i)) w_rd_word = r_regs[i];
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        S_AXI_ARREADY   = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) w_rd_state_next = RD_RESP;
            end
            RD_RESP: begin
                if (r_rvalid && S_AXI_RREADY) w_rd_state_next = RD_IDLE;
            end
            default: w_rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            r_rd_state <= w_rd_state_next;
            // Register array is sampled before this edge's write lands: old value wins.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_word;
                r_rresp  <= w_rd_in_range ? 2'b00 : 2'b10;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign reg_wr_pulse = r_wr_pulse;

endmodule
